// File: rtl/axi4_frame_writer.sv
// axi4_frame_writer
// Drains 64-bit RGB565 words from the camera FWFT FIFO into DDR as 64-beat
// INCR AXI4 write bursts. Frames alternate between two buffers, and
// buf_select flips only when a complete frame has landed.
//
// state       | meaning
// ------------+------------------------------------------------------------
// WAIT_FRAME  | idle; FIFO ignored until frame_start
// WAIT_DATA   | frame open; waiting for a full burst's worth of FIFO words
// ADDR        | AWVALID held with a stable AWADDR until AWREADY
// DATA        | streaming 64 beats; WVALID follows FIFO non-empty
// RESP        | BREADY high, waiting for the write response
module axi4_frame_writer #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURSTS_PER_FRAME = 300,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF0_ADDR = 32'h0100_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF1_ADDR = 32'h0110_0000
) (
  input  logic                        clk_100Mhz,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic [AXI_DATA_WIDTH-1:0]   fifo_dout,
  input  logic                        fifo_empty,
  input  logic                        fifo_burst_avail,
  output logic                        fifo_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic [3:0]                  AWCACHE,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic                        BVALID,
  output logic                        BREADY,
  input  logic [1:0]                  BRESP,
  output logic                        buf_select,
  output logic                        frame_done,
  output logic                        frame_drop,
  output logic                        resp_err,
  output logic [2:0]                  state
);

  typedef enum logic [2:0] {
    ST_WAIT_FRAME = 3'd0,
    ST_WAIT_DATA  = 3'd1,
    ST_ADDR       = 3'd2,
    ST_DATA       = 3'd3,
    ST_RESP       = 3'd4
  } state_t;

  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(512);

  state_t                      fsm_state;
  state_t                      state_d;
  logic [8:0]                  burst_cnt;
  logic [8:0]                  burst_cnt_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   addr_offset;
  logic [5:0]                  beat_cnt;
  logic                        start_pending;
  logic                        restart;
  logic                        last_burst;
  logic                        w_hs;
  logic                        in_data;

  logic                        clr_cnt;
  logic                        adv_cnt;
  logic                        latch_aw;
  logic                        aw_done;
  logic                        commit;
  logic                        drop;

  // fixed burst shape: 64 beats of 8 bytes, INCR, cacheable
  assign AWLEN   = 8'd63;
  assign AWSIZE  = 3'b011;
  assign AWBURST = 2'b01;
  assign AWCACHE = 4'b1111;
  assign WSTRB   = '1;
  assign WDATA   = fifo_dout;

  assign in_data    = (fsm_state == ST_DATA);
  assign WVALID     = in_data && !fifo_empty;
  assign WLAST      = in_data && (beat_cnt == 6'd63);
  assign w_hs       = WVALID && WREADY;
  assign fifo_rd_en = w_hs;
  assign state      = fsm_state;

  assign burst_cnt_nxt = burst_cnt + 9'd1;
  assign last_burst    = (burst_cnt_nxt == 9'(BURSTS_PER_FRAME));
  // a start seen on the response cycle itself counts the same as one recorded earlier
  assign restart       = start_pending || frame_start;

  // state register
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) fsm_state <= ST_WAIT_FRAME;
    else        fsm_state <= state_d;
  end

  // next-state and per-cycle control decode
  always_comb begin
    state_d  = fsm_state;
    clr_cnt  = 1'b0;
    adv_cnt  = 1'b0;
    latch_aw = 1'b0;
    aw_done  = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    case (fsm_state)
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          clr_cnt = 1'b1;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (frame_start) begin
          drop    = 1'b1;
          clr_cnt = 1'b1;
        end else if (fifo_burst_avail) begin
          latch_aw = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (AWREADY) begin
          aw_done = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs && WLAST) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (BVALID) begin
          if (last_burst) begin
            // a fully landed frame is always committed; a waiting start reopens at once
            commit  = 1'b1;
            clr_cnt = 1'b1;
            state_d = restart ? ST_WAIT_DATA : ST_WAIT_FRAME;
          end else if (restart) begin
            drop    = 1'b1;
            clr_cnt = 1'b1;
            state_d = ST_WAIT_DATA;
          end else begin
            adv_cnt = 1'b1;
            state_d = ST_WAIT_DATA;
          end
        end
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
  end

  // per-frame burst counter and byte offset
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt   <= '0;
      addr_offset <= '0;
    end else if (clr_cnt) begin
      burst_cnt   <= '0;
      addr_offset <= '0;
    end else if (adv_cnt) begin
      burst_cnt   <= burst_cnt_nxt;
      addr_offset <= addr_offset + BURST_BYTES;
    end
  end

  // write-address channel: address captured once, held stable through stalls
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      AWADDR  <= BUF1_ADDR;
      AWVALID <= 1'b0;
    end else if (latch_aw) begin
      AWADDR  <= (buf_select ? BUF0_ADDR : BUF1_ADDR) + addr_offset;
      AWVALID <= 1'b1;
    end else if (aw_done) begin
      AWVALID <= 1'b0;
    end
  end

  // beat counter within the current burst
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n)        beat_cnt <= '0;
    else if (aw_done)  beat_cnt <= '0;
    else if (w_hs)     beat_cnt <= beat_cnt + 6'd1;
  end

  // response-channel ready, raised after the last beat
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n)                                 BREADY <= 1'b0;
    else if (in_data && w_hs && WLAST)          BREADY <= 1'b1;
    else if (fsm_state == ST_RESP && BVALID)    BREADY <= 1'b0;
  end

  // remember a frame_start that arrives while a burst is in flight
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      start_pending <= 1'b0;
    end else if (fsm_state == ST_RESP && BVALID) begin
      start_pending <= 1'b0;
    end else if (frame_start && (fsm_state == ST_ADDR || fsm_state == ST_DATA ||
                                 fsm_state == ST_RESP)) begin
      start_pending <= 1'b1;
    end
  end

  // frame status: buffer swap, commit/drop pulses, sticky response error
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      buf_select <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      frame_done <= commit;
      frame_drop <= drop;
      if (commit) buf_select <= !buf_select;
      if (fsm_state == ST_RESP && BVALID && BRESP != 2'b00) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Bench for axi4_frame_writer: FIFO and AXI slave models driven on the
// falling edge, with a scoreboard monitor sampling just before each rising edge.
module tb_axi4_frame_writer;

  localparam int          BPF = 300;
  localparam logic [31:0] B0  = 32'h0100_0000;
  localparam logic [31:0] B1  = 32'h0110_0000;

  logic        clk_100Mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [63:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_burst_avail = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic [1:0]  BRESP = 2'b00;
  logic        buf_select;
  logic        frame_done;
  logic        frame_drop;
  logic        resp_err;
  logic [2:0]  state;

  axi4_frame_writer dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_burst_avail(fifo_burst_avail),
    .fifo_rd_en(fifo_rd_en), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWCACHE(AWCACHE),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .buf_select(buf_select),
    .frame_done(frame_done), .frame_drop(frame_drop), .resp_err(resp_err), .state(state)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic is_drop;
    logic buf_after;
  } ev_t;

  logic [63:0] fifo_q[$];
  logic [63:0] exp_wdata[$];
  logic [31:0] exp_aw[$];
  ev_t         exp_ev[$];

  // stimulus control
  int   stall_pct = 0;
  bit   err_frame = 0;
  int   drop_at = -1;
  bit   coincide = 0;
  bit   fs_req = 0;
  bit   pend_restart = 0;
  bit   pop_pending = 0;
  int   frame_b_cnt = 0;
  int   b_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    fifo_q.push_back(w);
    exp_wdata.push_back(w);
  endtask

  task automatic drive_cycle();
    @(negedge clk_100Mhz);
    if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_pending = 0;
    if (stall_pct == 0) begin
      while (fifo_q.size() < 256) push_word();
    end else if (fifo_q.size() < 256 && $urandom_range(99) < 60) begin
      push_word();
      push_word();
    end
    fifo_dout        = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
    fifo_empty       = (fifo_q.size() == 0) ||
                       (stall_pct != 0 && $urandom_range(99) < stall_pct);
    fifo_burst_avail = (fifo_q.size() >= 64);
    if (stall_pct == 0) begin
      AWREADY = 1'b1;
      WREADY  = 1'b1;
      BVALID  = 1'b1;
    end else begin
      AWREADY = ($urandom_range(99) >= stall_pct);
      WREADY  = ($urandom_range(99) >= stall_pct);
      BVALID  = ($urandom_range(99) >= stall_pct);
    end
    BRESP = (err_frame && state == 3'd4 && frame_b_cnt == 5) ? 2'b10 : 2'b00;
    frame_start = 1'b0;
    if (fs_req) begin
      frame_start = 1'b1;
      fs_req = 0;
    end
    if (drop_at >= 0 && state == 3'd3 && frame_b_cnt == drop_at) begin
      frame_start = 1'b1;
      drop_at = -1;
    end
    if (coincide && state == 3'd4 && BVALID && frame_b_cnt == BPF - 1) begin
      frame_start = 1'b1;
      coincide = 0;
    end
    #1;
    pop_pending = fifo_rd_en;
    if (BVALID && BREADY) begin
      b_total++;
      if (BRESP != 2'b00) err_frame = 0;
      if (frame_start || pend_restart) begin
        frame_b_cnt = 0;
        pend_restart = 0;
      end else begin
        frame_b_cnt = (frame_b_cnt + 1 == BPF) ? 0 : frame_b_cnt + 1;
      end
    end else if (frame_start) begin
      if (state == 3'd0 || state == 3'd1) frame_b_cnt = 0;
      else pend_restart = 1;
    end
  endtask

  task automatic run_bursts(input int n, input int limit, input string name);
    int start_b;
    int cyc;
    start_b = b_total;
    cyc = 0;
    while (b_total - start_b < n && cyc < limit) begin
      drive_cycle();
      cyc++;
    end
    check(name, 64'(b_total - start_b), 64'(n));
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int cyc;
    cyc = 0;
    while (state !== s && cyc < limit) begin
      drive_cycle();
      cyc++;
    end
    check(name, 64'(state), 64'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},      64'(state), 64'd0);
    check({tag, "_awvalid"},    64'(AWVALID), 64'd0);
    check({tag, "_awaddr"},     64'(AWADDR), 64'(B1));
    check({tag, "_wvalid"},     64'(WVALID), 64'd0);
    check({tag, "_wlast"},      64'(WLAST), 64'd0);
    check({tag, "_bready"},     64'(BREADY), 64'd0);
    check({tag, "_rd_en"},      64'(fifo_rd_en), 64'd0);
    check({tag, "_buf_select"}, 64'(buf_select), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check({tag, "_frame_drop"}, 64'(frame_drop), 64'd0);
    check({tag, "_resp_err"},   64'(resp_err), 64'd0);
  endtask

  task automatic expect_frame(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_aw.push_back(base + 32'(k * 512));
  endtask

  // scoreboard monitor: samples 2 ns before each rising edge
  int          mon_beat = 0;
  bit          aw_hold = 0;
  logic [31:0] aw_hold_addr = '0;
  bit          err_model = 0;

  always @(negedge clk_100Mhz) begin
    #3;
    if (!rst_n) begin
      mon_beat = 0;
      aw_hold = 0;
      err_model = 0;
    end else begin
      check("resp_err", 64'(resp_err), 64'(err_model));
      if (aw_hold) begin
        check("aw_stable_valid", 64'(AWVALID), 64'd1);
        check("aw_stable_addr", 64'(AWADDR), 64'(aw_hold_addr));
      end
      aw_hold = AWVALID && !AWREADY;
      aw_hold_addr = AWADDR;
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 64'(AWADDR), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("awaddr", 64'(AWADDR), 64'(exp_aw.pop_front()));
        mon_beat = 0;
      end
      if (WVALID || fifo_rd_en)
        check("rd_en_eq_whs", 64'(fifo_rd_en), 64'(WVALID && WREADY));
      if (WVALID) check("wlast_pos", 64'(WLAST), 64'(mon_beat == 63));
      if (WVALID && WREADY) begin
        if (exp_wdata.size() == 0) check("wdata_underrun", 64'd1, 64'd0);
        else check("wdata", WDATA, exp_wdata.pop_front());
        mon_beat++;
      end
      if (BVALID && BREADY) begin
        check("beats_per_burst", 64'(mon_beat), 64'd64);
        if (BRESP != 2'b00) err_model = 1;
      end
      if (frame_done || frame_drop) begin
        if (exp_ev.size() == 0) begin
          check("event_unexpected", {62'd0, frame_drop, frame_done}, 64'd0);
        end else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("event_kind", {62'd0, frame_drop, frame_done}, {62'd0, e.is_drop, !e.is_drop});
          check("event_buf", 64'(buf_select), 64'(e.buf_after));
        end
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) drive_cycle();
    check_reset_vals("reset");
    check("awlen",   64'(AWLEN), 64'd63);
    check("awsize",  64'(AWSIZE), 64'd3);
    check("awburst", 64'(AWBURST), 64'd1);
    check("awcache", 64'(AWCACHE), 64'hF);
    check("wstrb",   64'(WSTRB), 64'hFF);
    rst_n = 1'b1;
    repeat (3) drive_cycle();
    check("idle_no_aw", 64'(AWVALID), 64'd0);

    // frame 1: ideal slave, full FIFO -> buffer 1, then buf_select 0->1
    stall_pct = 0;
    expect_frame(B1, BPF);
    exp_ev.push_back('{is_drop: 1'b0, buf_after: 1'b1});
    fs_req = 1;
    run_bursts(BPF, 21000, "f1_bursts");
    drive_cycle();
    check("f1_state", 64'(state), 64'd0);
    check("f1_buf", 64'(buf_select), 64'd1);
    check("f1_aw_left", 64'(exp_aw.size()), 64'd0);

    // frame 2: random stalls, FIFO gaps, error response on burst 5
    stall_pct = 10;
    err_frame = 1;
    expect_frame(B0, BPF);
    exp_ev.push_back('{is_drop: 1'b0, buf_after: 1'b0});
    fs_req = 1;
    run_bursts(BPF, 35000, "f2_bursts");
    drive_cycle();
    drive_cycle();
    check("f2_buf", 64'(buf_select), 64'd0);
    check("f2_resp_err", 64'(resp_err), 64'd1);
    check("f2_state", 64'(state), 64'd0);

    // frame 3: start mid-DATA of burst 100 drops; restart commits with a
    // start coinciding with the final response
    stall_pct = 0;
    expect_frame(B1, 101);
    exp_ev.push_back('{is_drop: 1'b1, buf_after: 1'b0});
    expect_frame(B1, BPF);
    exp_ev.push_back('{is_drop: 1'b0, buf_after: 1'b1});
    exp_aw.push_back(B0);
    drop_at = 100;
    coincide = 1;
    fs_req = 1;
    run_bursts(101 + BPF, 28000, "f3_bursts");
    drive_cycle();
    check("f3_buf", 64'(buf_select), 64'd1);
    check("f3_state_reopened", 64'(state), 64'd1);
    check("f3_resp_err_sticky", 64'(resp_err), 64'd1);

    // asynchronous reset in the middle of a data phase
    wait_state(3'd3, 200, "reach_data");
    repeat (10) drive_cycle();
    @(negedge clk_100Mhz);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) drive_cycle();
    rst_n = 1'b1;
    repeat (10) drive_cycle();
    check("post_rst_state", 64'(state), 64'd0);
    check("post_rst_awvalid", 64'(AWVALID), 64'd0);
    exp_aw.push_back(B1);
    fs_req = 1;
    run_bursts(1, 300, "post_rst_burst");
    drive_cycle();
    check("end_aw_left", 64'(exp_aw.size()), 64'd0);
    check("end_ev_left", 64'(exp_ev.size()), 64'd0);
    check("end_buf", 64'(buf_select), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi4_frame_writer.md
# axi4_frame_writer

Upstream stage of the DDR double frame buffer: drains 64-bit packed RGB565 words (4 pixels/word) from the camera-side FWFT FIFO and writes them into PS DDR as 64-beat INCR AXI4 bursts. It owns `buf_select`. It writes into the buffer not being displayed and toggles `buf_select` when a full 320×240 frame lands, so the display reader switches to the fresh buffer. Runs entirely on `clk_100Mhz`.

## Interface
- AXI_ADDR_WIDTH, 32, AXI address width
- AXI_DATA_WIDTH, 64, AXI/FIFO data width
- BURSTS_PER_FRAME, 300, bursts per frame (300 × 512 B = 153600 B)
- BUF0_ADDR, 32'h0100_0000, buffer 0 base (read when buf_select=0)
- BUF1_ADDR, 32'h0110_0000, buffer 1 base (read when buf_select=1)
- clk_100Mhz  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse, camera vsync already synchronized to clk_100Mhz
- fifo_dout  in  64  FWFT FIFO head word
- fifo_empty  in  1  FIFO empty
- fifo_burst_avail  in  1  FIFO holds ≥64 words (prog_full-style threshold)
- fifo_rd_en  out  1  pop; equals WVALID && WREADY
- AWADDR  out  32  burst address; AWVALID out 1; AWREADY in 1
- AWLEN out 8 = 63; AWSIZE out 3 = 3'b011; AWBURST out 2 = 2'b01; AWCACHE out 4 = 4'b1111 (constants)
- WDATA  out  64  = fifo_dout; WSTRB out 8 = 8'hFF; WLAST out 1; WVALID out 1; WREADY in 1
- BVALID in 1; BREADY out 1; BRESP in 2
- buf_select  out  1  buffer the reader displays
- frame_done  out  1  one-cycle pulse on frame commit
- frame_drop  out  1  one-cycle pulse when a partial frame is abandoned
- resp_err  out  1  sticky; set on any BRESP≠0, cleared only by reset
- state  out  3  FSM state (debug)

## Operation
- Write target = (buf_select ? BUF0_ADDR : BUF1_ADDR), i.e. always the non-displayed buffer.
- Per-frame registers: burst_cnt (9 bit, 0..299) and ADDR_OFFSET (32 bit, +512 per burst).
- States: WAIT_FRAME(0), WAIT_DATA(1), ADDR(2), DATA(3), RESP(4).
- WAIT_FRAME: ignore FIFO. On frame_start, clear burst_cnt and offset, then go to WAIT_DATA.
- WAIT_DATA: on fifo_burst_avail, latch AWADDR = target + ADDR_OFFSET, set AWVALID=1, then go to ADDR.
- ADDR: hold AWVALID and AWADDR until AWREADY. On the handshake, drop AWVALID, clear beat_cnt (6 bit), then go to DATA.
- DATA: WVALID = !fifo_empty (combinational). WLAST = (beat_cnt==63). beat_cnt increments on each W handshake. The handshake on WLAST goes to RESP with BREADY=1.
- RESP: on BVALID, drop BREADY, set resp_err if BRESP≠0, offset += 512, burst_cnt += 1.
  - If the new burst_cnt == BURSTS_PER_FRAME: toggle buf_select, pulse frame_done, then go to WAIT_FRAME.
  - Otherwise go to WAIT_DATA.
- An error response does not stop the frame.
- frame_start in WAIT_DATA (frame incomplete): pulse frame_drop, clear counters, stay in WAIT_DATA, leave buf_select unchanged.
- frame_start during ADDR/DATA/RESP: record pending flag. The burst completes normally (AXI transactions are never aborted). On the RESP exit, apply the drop behaviour above instead of the increment/commit.
- frame_start coinciding with the final burst's BVALID: the commit wins (frame_done, toggle). The pending start then moves the FSM to WAIT_DATA with counters cleared, not to WAIT_FRAME.

## Timing
- Reset (async assert, sync release) values: state=WAIT_FRAME, AWVALID=0, AWADDR=BUF1_ADDR, WVALID=0, WLAST=0, BREADY=0, fifo_rd_en=0, buf_select=0, frame_done=0, frame_drop=0, resp_err=0, counters=0.
- AWVALID rises 1 cycle after fifo_burst_avail is sampled in WAIT_DATA.
- The first WVALID can assert the cycle after the AW handshake.
- Best case per burst: 1 + 1 + 64 + 1 + B latency cycles.
- WVALID, once high, stays high until the handshake, as long as the FIFO stays non-empty. The FIFO never underflows mid-burst, because a burst starts only with ≥64 words present.
- AW and W are strictly serialized. There is never more than one outstanding transaction.
- buf_select and frame_done change on the same edge.

## Test plan
- Ideal slave (AWREADY/WREADY/BVALID always 1) and full FIFO, frame_start once -> 300 bursts at AWADDR 0x0110_0000, 0x0110_0200 … 0x0112_5600. Then frame_done pulses once, buf_select 0→1, and the FSM returns to WAIT_FRAME.
- Second frame_start -> bursts start at 0x0100_0000. After the commit, buf_select returns to 0.
- Random WREADY/AWREADY stalls and FIFO empty gaps -> exactly 64 pops per burst, WLAST only on beat 63, AWADDR/AWVALID stable while stalled, WDATA sequence matches the FIFO order.
- frame_start mid-DATA at burst 100 -> the burst finishes and frame_drop pulses once. The next AWADDR is the target base with offset 0, and buf_select is unchanged.
- BRESP=2'b10 on burst 5 -> resp_err=1 and sticky, the frame still commits after 300 bursts.
- Assert rst_n low during DATA -> all outputs return to reset values asynchronously. After release, the FSM waits for frame_start.
